// File: rtl/ppu_timing_gen.sv
// Scanline/frame timing for the picture unit: beam position, vblank flag, NMI,
// pixel window, background fetch cadence and the NTSC odd-frame cycle skip.
module ppu_timing_gen #(
   parameter int  CYC_PER_LINE    = 341,
   parameter int  LINES_PER_FRAME = 262,
   parameter int  VISIBLE_LINES   = 240,
   parameter int  VBLANK_LINE     = 241,
   parameter int  ODD_SKIP        = 1,
   localparam int CW              = $clog2(CYC_PER_LINE),
   localparam int LW              = $clog2(LINES_PER_FRAME)
) (
   input  logic          PPUCLK,
   input  logic          RST,
   input  logic          NMI_EN,
   input  logic          RENDER_EN,
   input  logic          STATUS_RD,
   output logic [CW-1:0] N_CYC,
   output logic [LW-1:0] N_LINE,
   output logic          VBLANK_FLAG,
   output logic          NMI,
   output logic          VISIBLE,
   output logic          FETCH_VALID,
   output logic [1:0]    FETCH_KIND,
   output logic          ODD_FRAME,
   output logic          FRAME_START
);

   localparam int            PRE      = LINES_PER_FRAME - 1;
   localparam logic [CW-1:0] CYC_ZERO = '0;
   localparam logic [CW-1:0] CYC_ONE  = CW'(1);
   localparam logic [CW-1:0] CYC_LAST = CW'(CYC_PER_LINE - 1);
   localparam logic [CW-1:0] CYC_SKIP = CW'(CYC_PER_LINE - 2);
   localparam logic [CW-1:0] CYC_256  = CW'(256);
   localparam logic [CW-1:0] CYC_321  = CW'(321);
   localparam logic [CW-1:0] CYC_336  = CW'(336);
   localparam logic [LW-1:0] LINE_ZERO = '0;
   localparam logic [LW-1:0] LINE_ONE  = LW'(1);
   localparam logic [LW-1:0] LINE_PRE  = LW'(PRE);
   localparam logic [LW-1:0] LINE_VBL  = LW'(VBLANK_LINE);
   localparam logic [LW-1:0] LINE_VIS  = LW'(VISIBLE_LINES);

   logic [CW-1:0] cyc_q;
   logic [LW-1:0] line_q;
   logic          vblank_q;
   logic          nmi_q;
   logic          odd_q;

   logic          at_pre;
   logic          at_line_end;
   logic          skip_now;
   logic          set_vbl;
   logic          clr_vbl;

   assign at_pre      = (line_q == LINE_PRE);
   assign at_line_end = (cyc_q == CYC_LAST);
   // RENDER_EN only matters on the one decision cycle of an odd pre-render line.
   assign skip_now    = (ODD_SKIP != 0) && RENDER_EN && odd_q && at_pre && (cyc_q == CYC_SKIP);
   assign set_vbl     = (line_q == LINE_VBL) && (cyc_q == CYC_ONE);
   assign clr_vbl     = at_pre && (cyc_q == CYC_ONE);

   always_ff @(posedge PPUCLK) begin
      if (RST) begin
         cyc_q    <= CYC_ZERO;
         line_q   <= LINE_PRE;
         vblank_q <= 1'b0;
         nmi_q    <= 1'b0;
         odd_q    <= 1'b0;
      end else begin
         if (skip_now || (at_line_end && at_pre)) begin
            cyc_q  <= CYC_ZERO;
            line_q <= LINE_ZERO;
            odd_q  <= ~odd_q;
         end else if (at_line_end) begin
            cyc_q  <= CYC_ZERO;
            line_q <= line_q + LINE_ONE;
         end else begin
            cyc_q <= cyc_q + CYC_ONE;
         end

         // A status read coinciding with the set cycle wins, so that frame never flags.
         if (clr_vbl || STATUS_RD) begin
            vblank_q <= 1'b0;
         end else if (set_vbl) begin
            vblank_q <= 1'b1;
         end

         nmi_q <= vblank_q & NMI_EN;
      end
   end

   logic [2:0] phase;
   logic       in_render_line;
   logic       in_fetch_cyc;
   logic       in_pixel_cyc;
   logic       fetch_win;

   // Low three bits of (cycle - 1) give the position inside the 8-cycle fetch group.
   assign phase = cyc_q[2:0] - 3'd1;

   always_comb begin
      in_pixel_cyc   = (cyc_q >= CYC_ONE) && (cyc_q <= CYC_256);
      in_render_line = (line_q < LINE_VIS) || at_pre;
      in_fetch_cyc   = in_pixel_cyc || ((cyc_q >= CYC_321) && (cyc_q <= CYC_336));
      fetch_win      = RENDER_EN && !RST && in_render_line && in_fetch_cyc;
      FETCH_VALID    = fetch_win && !phase[0];
      FETCH_KIND     = fetch_win ? phase[2:1] : 2'b00;
      VISIBLE        = (line_q < LINE_VIS) && in_pixel_cyc;
      FRAME_START    = (line_q == LINE_ZERO) && (cyc_q == CYC_ZERO) && !RST;
   end

   assign N_CYC       = cyc_q;
   assign N_LINE      = line_q;
   assign VBLANK_FLAG = vblank_q;
   assign NMI         = nmi_q;
   assign ODD_FRAME   = odd_q;

endmodule

// File: tb/tb_ppu_timing_gen.sv
// Bench for ppu_timing_gen: a shortened frame (12 lines) keeps runs small while the
// full 341-cycle line exercises the real fetch windows; a second copy has the skip off.
module tb_ppu_timing_gen;

   localparam int CPL   = 341;
   localparam int LPF   = 12;
   localparam int VIS   = 8;
   localparam int VBL   = 9;
   localparam int PRE   = LPF - 1;
   localparam int FRAME = CPL * LPF;

   logic       ppuclk;
   logic       rst;
   logic       nmi_en;
   logic       render_en;
   logic       status_rd;

   logic [8:0] n_cyc0, n_cyc1;
   logic [3:0] n_line0, n_line1;
   logic       vblank0, vblank1, nmi0, nmi1, visible0, visible1;
   logic       fvalid0, fvalid1, odd0, odd1, fs0, fs1;
   logic [1:0] fkind0, fkind1;

   int line0, cyc0;
   assign line0 = int'(n_line0);
   assign cyc0  = int'(n_cyc0);

   int          n_checks;
   int          n_pass;
   logic [31:0] exp_q[$];
   logic [31:0] exp1_q[$];

   ppu_timing_gen #(
      .CYC_PER_LINE(CPL), .LINES_PER_FRAME(LPF), .VISIBLE_LINES(VIS),
      .VBLANK_LINE(VBL), .ODD_SKIP(1)
   ) dut (
      .PPUCLK(ppuclk), .RST(rst), .NMI_EN(nmi_en), .RENDER_EN(render_en),
      .STATUS_RD(status_rd), .N_CYC(n_cyc0), .N_LINE(n_line0),
      .VBLANK_FLAG(vblank0), .NMI(nmi0), .VISIBLE(visible0),
      .FETCH_VALID(fvalid0), .FETCH_KIND(fkind0), .ODD_FRAME(odd0),
      .FRAME_START(fs0)
   );

   ppu_timing_gen #(
      .CYC_PER_LINE(CPL), .LINES_PER_FRAME(LPF), .VISIBLE_LINES(VIS),
      .VBLANK_LINE(VBL), .ODD_SKIP(0)
   ) dut_pal (
      .PPUCLK(ppuclk), .RST(rst), .NMI_EN(nmi_en), .RENDER_EN(render_en),
      .STATUS_RD(status_rd), .N_CYC(n_cyc1), .N_LINE(n_line1),
      .VBLANK_FLAG(vblank1), .NMI(nmi1), .VISIBLE(visible1),
      .FETCH_VALID(fvalid1), .FETCH_KIND(fkind1), .ODD_FRAME(odd1),
      .FRAME_START(fs1)
   );

   // Clock / watchdog
   initial begin
      ppuclk = 1'b0;
      forever #5 ppuclk = ~ppuclk;
   end

   initial begin
      #(120000 * 10);
      $display("FAIL watchdog: simulation exceeded 120000 cycles");
      $fatal(1, "watchdog expired");
   end

   // Driver tasks
   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge ppuclk);
      rst = 1'b0;
   endtask

   task automatic wait_pos(input int l, input int c, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge ppuclk);
         n++;
      end while (!(line0 == l && cyc0 == c) && n < 2 * FRAME + CPL);
      if (!(line0 == l && cyc0 == c)) begin
         n_checks++;
         $display("FAIL %s_wait: at line %0d cyc %0d, wanted line %0d cyc %0d", tag, line0, cyc0, l, c);
      end
   endtask

   // Scenarios
   task automatic test_reset();
      logic [31:0] got, e;
      render_en = 1'b1;
      nmi_en    = 1'b1;
      status_rd = 1'b0;
      rst       = 1'b1;
      repeat (3) @(negedge ppuclk);
      exp_q = {};
      exp_q.push_back(32'({9'd0, 4'(PRE), 5'b00000}));
      exp_q.push_back(32'({9'd0, 4'(PRE), 5'b00000}));
      got = 32'({n_cyc0, n_line0, vblank0, nmi0, odd0, fs0, fvalid0});
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL reset_state: got %h want %h", got, e); else n_pass++;
      got = 32'({n_cyc1, n_line1, vblank1, nmi1, odd1, fs1, fvalid1});
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL reset_state_pal: got %h want %h", got, e); else n_pass++;
      rst = 1'b0;
      @(negedge ppuclk);
      exp_q.push_back(32'({9'd1, 4'(PRE)}));
      got = 32'({n_cyc0, n_line0});
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL reset_first_step: got %h want %h", got, e); else n_pass++;
   endtask

   // mode 0: render off, 1: render on, 2: on only at decision cycle, 3: off only there
   task automatic test_frame_len(input int mode);
      int          t, last0, last1, budget;
      int          pc, pl;
      logic        po, pr;
      logic [31:0] e;
      nmi_en    = 1'b0;
      status_rd = 1'b0;
      render_en = (mode == 1) || (mode == 3);
      do_reset();
      exp_q  = {};
      exp1_q = {};
      exp_q.push_back(32'(CPL));
      exp_q.push_back((mode == 1 || mode == 2) ? 32'(FRAME - 1) : 32'(FRAME));
      exp_q.push_back(32'(FRAME));
      exp1_q.push_back(32'(CPL));
      exp1_q.push_back(32'(FRAME));
      exp1_q.push_back(32'(FRAME));
      t = 0; last0 = 0; last1 = 0;
      budget = CPL + 2 * FRAME + 20;
      while ((exp_q.size() > 0 || exp1_q.size() > 0) && t < budget) begin
         if (mode == 2) render_en = (line0 == PRE && cyc0 == CPL - 2);
         else if (mode == 3) render_en = !(line0 == PRE && cyc0 == CPL - 2);
         pc = cyc0; pl = line0; po = odd0; pr = render_en;
         @(negedge ppuclk);
         t++;
         if (pl == PRE && pc == CPL - 2) begin
            n_checks++;
            if (po && pr) begin
               if (line0 != 0 || cyc0 != 0)
                  $display("FAIL skip_m%0d: after decision got (%0d,%0d) want (0,0)", mode, line0, cyc0);
               else n_pass++;
            end else begin
               if (line0 != PRE || cyc0 != CPL - 1)
                  $display("FAIL noskip_m%0d: after decision got (%0d,%0d) want (%0d,%0d)", mode, line0, cyc0, PRE, CPL - 1);
               else n_pass++;
            end
         end
         if (fs0 === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL frame_len_m%0d: extra frame start, got %0d want none", mode, t - last0);
            else begin
               e = exp_q.pop_front();
               if (32'(t - last0) !== e) $display("FAIL frame_len_m%0d: got %0d want %0d", mode, t - last0, e);
               else n_pass++;
            end
            last0 = t;
         end
         if (fs1 === 1'b1) begin
            n_checks++;
            if (exp1_q.size() == 0) $display("FAIL frame_len_pal_m%0d: extra frame start, got %0d want none", mode, t - last1);
            else begin
               e = exp1_q.pop_front();
               if (32'(t - last1) !== e) $display("FAIL frame_len_pal_m%0d: got %0d want %0d", mode, t - last1, e);
               else n_pass++;
            end
            last1 = t;
         end
      end
      if (exp_q.size() > 0 || exp1_q.size() > 0) begin
         n_checks++;
         $display("FAIL frame_len_m%0d_timeout: got %0d/%0d pending starts want 0", mode, exp_q.size(), exp1_q.size());
         exp_q = {};
         exp1_q = {};
      end
      n_checks++;
      if (odd0 !== 1'b1 || odd1 !== 1'b1) $display("FAIL odd_frame_m%0d: got %b%b want 11", mode, odd0, odd1);
      else n_pass++;
   endtask

   task automatic test_vblank_nmi();
      logic [31:0] got, e;
      nmi_en = 1'b1; render_en = 1'b0; status_rd = 1'b0;
      do_reset();
      wait_pos(VBL, 1, "vbl_set");
      exp_q = {};
      exp_q.push_back(32'b00); exp_q.push_back(32'b10); exp_q.push_back(32'b11);
      exp_q.push_back(32'b10); exp_q.push_back(32'b11);
      for (int i = 0; i < 5; i++) begin
         got = {30'd0, vblank0, nmi0};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) $display("FAIL vbl_rise_step%0d: got %b want %b", i, got[1:0], e[1:0]); else n_pass++;
         if (i == 2) nmi_en = 1'b0;
         if (i == 3) nmi_en = 1'b1;
         @(negedge ppuclk);
      end
      wait_pos(PRE, 1, "vbl_clr");
      exp_q.push_back(32'b11); exp_q.push_back(32'b01); exp_q.push_back(32'b00);
      for (int i = 0; i < 3; i++) begin
         got = {30'd0, vblank0, nmi0};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) $display("FAIL vbl_fall_step%0d: got %b want %b", i, got[1:0], e[1:0]); else n_pass++;
         @(negedge ppuclk);
      end
   endtask

   task automatic test_status_rd();
      logic [31:0] got, e;
      int          n;
      logic        seen;
      nmi_en = 1'b1; render_en = 1'b0; status_rd = 1'b0;
      do_reset();
      wait_pos(VBL, 1, "srd_race");
      status_rd = 1'b1;
      @(negedge ppuclk);
      status_rd = 1'b0;
      seen = 1'b0; n = 0;
      while (!(line0 == PRE && cyc0 == 5) && n < 4 * CPL) begin
         if (vblank0 !== 1'b0 || nmi0 !== 1'b0) seen = 1'b1;
         @(negedge ppuclk);
         n++;
      end
      n_checks++;
      if (seen !== 1'b0 || n >= 4 * CPL) $display("FAIL srd_suppress: got flag_seen=%b cycles=%0d want flag_seen=0", seen, n);
      else n_pass++;
      wait_pos(VBL + 1, 0, "srd_clear");
      exp_q = {};
      exp_q.push_back(32'b11); exp_q.push_back(32'b01); exp_q.push_back(32'b00);
      for (int i = 0; i < 3; i++) begin
         got = {30'd0, vblank0, nmi0};
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) $display("FAIL srd_clear_step%0d: got %b want %b", i, got[1:0], e[1:0]); else n_pass++;
         status_rd = (i == 0);
         @(negedge ppuclk);
      end
      status_rd = 1'b0;
   endtask

   task automatic test_fetch();
      int          lines[3];
      int          l, s;
      logic        in_line, in_cyc, vis_b, valid_b;
      logic [1:0]  kind_b;
      logic [31:0] got, e;
      lines = '{PRE, 5, VBL};
      nmi_en = 1'b0; render_en = 1'b1; status_rd = 1'b0;
      do_reset();
      for (int li = 0; li < 3; li++) begin
         l = lines[li];
         if (li > 0) wait_pos(l, 0, "fetch");
         exp_q = {};
         for (int c = 0; c < CPL; c++) begin
            in_line = (l < VIS) || (l == PRE);
            in_cyc  = (c >= 1 && c <= 256) || (c >= 321 && c <= 336);
            s       = (c + 7) % 8;
            vis_b   = (l < VIS) && (c >= 1) && (c <= 256);
            valid_b = in_line && in_cyc && (s % 2 == 0);
            kind_b  = (in_line && in_cyc) ? 2'(s / 2) : 2'd0;
            exp_q.push_back({18'd0, 9'(c), 1'b0, vis_b, valid_b, kind_b});
         end
         for (int c = 0; c < CPL; c++) begin
            got = {18'd0, n_cyc0, 1'b0, visible0, fvalid0, fkind0};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL fetch_l%0d_c%0d: got %h want %h", l, c, got, e); else n_pass++;
            @(negedge ppuclk);
         end
      end
   endtask

   task automatic test_reset_mid();
      int          n;
      logic [31:0] e;
      nmi_en = 1'b1; render_en = 1'b1; status_rd = 1'b0;
      do_reset();
      wait_pos(5, 1, "rst_fetch");
      n_checks++;
      if (fvalid0 !== 1'b1) $display("FAIL fetch_pre_rst: got %b want 1", fvalid0); else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if (fvalid0 !== 1'b0) $display("FAIL fetch_in_rst: got %b want 0", fvalid0); else n_pass++;
      @(negedge ppuclk);
      rst = 1'b0;
      wait_pos(0, 0, "rst_fs");
      n_checks++;
      if (fs0 !== 1'b1) $display("FAIL fs_pre_rst: got %b want 1", fs0); else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if (fs0 !== 1'b0) $display("FAIL fs_in_rst: got %b want 0", fs0); else n_pass++;
      @(negedge ppuclk);
      rst = 1'b0;
      wait_pos(VBL + 1, 100, "rst_vbl");
      n_checks++;
      if (nmi0 !== 1'b1) $display("FAIL nmi_pre_rst: got %b want 1", nmi0); else n_pass++;
      rst = 1'b1;
      @(negedge ppuclk);
      rst = 1'b0;
      n_checks++;
      if (nmi0 !== 1'b0 || vblank0 !== 1'b0 || odd0 !== 1'b0 || line0 != PRE || cyc0 != 0)
         $display("FAIL rst_in_vbl: got nmi=%b vbl=%b odd=%b (%0d,%0d) want 0 0 0 (%0d,0)",
                  nmi0, vblank0, odd0, line0, cyc0, PRE);
      else n_pass++;
      wait_pos(0, 0, "rst_skip_a");
      wait_pos(PRE, CPL - 2, "rst_skip_b");
      n_checks++;
      if (odd0 !== 1'b1) $display("FAIL odd_before_skip: got %b want 1", odd0); else n_pass++;
      rst = 1'b1;
      @(negedge ppuclk);
      rst = 1'b0;
      exp_q = {};
      exp_q.push_back(32'(CPL));
      n = 0;
      while (fs0 !== 1'b1 && n < 2 * CPL) begin
         @(negedge ppuclk);
         n++;
      end
      e = exp_q.pop_front();
      n_checks++;
      if (32'(n) !== e) $display("FAIL no_pending_skip: got %0d cycles to frame start want %0d", n, e); else n_pass++;
   endtask

   // Sequence and report
   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b1;
      nmi_en    = 1'b0;
      render_en = 1'b0;
      status_rd = 1'b0;
      test_reset();
      for (int m = 0; m < 4; m++) test_frame_len(m);
      test_vblank_nmi();
      test_status_rd();
      test_fetch();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ppu_timing_gen.md
PPU_TIMING_GEN -- requirements
Module: ppu_timing_gen

Interface
REQ-001 SHALL have parameter CYC_PER_LINE, default 341, meaning PPU clocks per scanline.
REQ-002 SHALL have parameter LINES_PER_FRAME, default 262, meaning scanlines per frame.
REQ-003 SHALL have parameter VISIBLE_LINES, default 240, meaning visible scanlines 0..VISIBLE_LINES-1.
REQ-004 SHALL have parameter VBLANK_LINE, default 241, meaning the scanline on which vblank starts.
REQ-005 SHALL have parameter ODD_SKIP, default 1, meaning 1 = odd-frame cycle skip enabled (NTSC), 0 = disabled (PAL).
REQ-006 SHALL derive CW = $clog2(CYC_PER_LINE) and LW = $clog2(LINES_PER_FRAME); the pre-render line is PRE = LINES_PER_FRAME-1.
REQ-007 SHALL have port PPUCLK, input, 1, the single clock for all logic; one clock, reset synchronous and active-high.
REQ-008 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-009 SHALL have port NMI_EN, input, 1, PPUCTRL bit 7.
REQ-010 SHALL have port RENDER_EN, input, 1, OR of PPUMASK background/sprite enables.
REQ-011 SHALL have port STATUS_RD, input, 1, one-cycle strobe for a $2002 read.
REQ-012 SHALL have port N_CYC, output, CW, current cycle.
REQ-013 SHALL have port N_LINE, output, LW, current scanline.
REQ-014 SHALL have port VBLANK_FLAG, output, 1, PPUSTATUS bit 7.
REQ-015 SHALL have port NMI, output, 1, active-high NMI request level.
REQ-016 SHALL have port VISIBLE, output, 1, pixel-output window.
REQ-017 SHALL have port FETCH_VALID, output, 1, a background fetch starts this cycle.
REQ-018 SHALL have port FETCH_KIND, output, 2, fetch type: 0=NT, 1=AT, 2=BMPL, 3=BMPH.
REQ-019 SHALL have port ODD_FRAME, output, 1, frame parity.
REQ-020 SHALL have port FRAME_START, output, 1, one-cycle pulse at line 0 cycle 0.

Function
REQ-021 N_CYC SHALL increment each cycle; after CYC_PER_LINE-1 it SHALL wrap to 0 and N_LINE SHALL increment.
REQ-022 N_LINE SHALL wrap from PRE to 0; on that wrap ODD_FRAME SHALL toggle.
REQ-023 When ODD_SKIP=1, RENDER_EN=1 and ODD_FRAME=1 at line PRE, cycle CYC_PER_LINE-2, the next state SHALL be line 0, cycle 0; that line-0 transition SHALL toggle ODD_FRAME and pulse FRAME_START.
REQ-024 RENDER_EN SHALL be sampled only at the skip-decision cycle; changes at any other time have no effect on the skip.
REQ-025 VBLANK_FLAG SHALL be set on the clock edge leaving line VBLANK_LINE, cycle 1.
REQ-026 VBLANK_FLAG SHALL be cleared on the clock edge leaving line PRE, cycle 1.
REQ-027 STATUS_RD=1 SHALL clear VBLANK_FLAG on the next edge.
REQ-028 STATUS_RD=1 during line VBLANK_LINE, cycle 1 SHALL suppress the set for that frame, and the flag SHALL stay 0.
REQ-029 NMI SHALL be a registered copy of VBLANK_FLAG & NMI_EN with 1-cycle latency.
REQ-030 Raising NMI_EN while VBLANK_FLAG=1 SHALL assert NMI one cycle later.
REQ-031 Dropping NMI_EN or VBLANK_FLAG SHALL deassert NMI one cycle later.
REQ-032 VISIBLE SHALL be combinational: 1 when N_LINE < VISIBLE_LINES and 1 <= N_CYC <= 256.
REQ-033 The fetch window SHALL be defined as RENDER_EN=1, (N_LINE < VISIBLE_LINES or N_LINE == PRE), and N_CYC in 1..256 or 321..336.
REQ-034 Within the fetch window, with s = (N_CYC-1) mod 8: FETCH_VALID=1 when s is even and FETCH_KIND = s/2.
REQ-035 Outside the fetch window, FETCH_VALID=0 and FETCH_KIND=0.
REQ-036 FRAME_START SHALL be 1 exactly when N_LINE=0 and N_CYC=0 and RST=0.

Reset
REQ-037 While RST=1 at an edge, the next state SHALL be: N_CYC=0, N_LINE=PRE, VBLANK_FLAG=0, NMI=0, ODD_FRAME=0.
REQ-038 While RST=1, FRAME_START=0 and FETCH_VALID=0.
REQ-039 Reset mid-frame, including during vblank or the skip cycle, SHALL abandon the frame with no NMI and no pending skip.
REQ-040 The first frame after reset SHALL begin at PRE, cycle 0, and be treated as even.

Verification
REQ-041 Defaults, RENDER_EN=0, run 2 frames -> each frame exactly 89342 cycles; FRAME_START period 89342.
REQ-042 RENDER_EN=1 -> frame lengths alternate 89342 (even), 89341 (odd); odd frame passes (261,339) -> (0,0).
REQ-043 NMI_EN=1 -> VBLANK_FLAG rises after (241,1), NMI one cycle later, both fall after (261,1).
REQ-044 STATUS_RD at (241,1) -> VBLANK_FLAG and NMI stay 0 all frame; STATUS_RD at (250,0) -> flag cleared at next edge.
REQ-045 RENDER_EN=1, line 5 -> FETCH_VALID at cycles 1,3,5,7 with KIND 0,1,2,3; none at 257..320; resumes at 321; none on line 241.
REQ-046 RST asserted at (245,100) with NMI=1 -> next cycle NMI=0, N_LINE=261, N_CYC=0; ODD_SKIP=0 build never skips.
